// File: rtl/controller_instruction_rom_loader.sv
// ---------------------------------------------------------------------------
// controller_instruction_rom_loader
//
// Purpose
//   Boot loader for the controller's dual-port instruction RAM, driving the
//   RAM's second Avalon-MM slave port (s2). A framed byte stream from the host
//   link is packed into little-endian 32-bit words, which are written from
//   word 0 upward. The image is then read back and its sum is compared with the
//   sum of the written words. The CPU is held in reset for the whole load.
//
//   Frame: LEN_LO, LEN_HI (N = word count), 4*N data bytes (LSB first),
//          4 checksum bytes (LSB first); checksum = sum of data words mod 2^32.
//
// Handshake
//   A byte moves on every rising clk edge where in_valid & in_ready are both
//   high. in_ready depends only on the registered state, never on in_valid, so
//   the source may hold in_valid low (stall) for any number of cycles.
//
// Ports
//   clk, reset      system clock; synchronous active-high reset
//   start           1-cycle arm pulse, honoured only in IDLE/DONE/ERROR
//   in_data/valid   stream byte and its valid
//   in_ready        loader can accept a byte this cycle
//   mem_*           Avalon-MM master to RAM port s2 (readdata 1 cycle latency)
//   cpu_hold        CPU reset request, high while the loader is busy
//   busy            high outside IDLE, DONE and ERROR
//   done / error    sticky result levels, cleared by the next start
//   err_code        0 none, 1 bad length, 2 checksum mismatch,
//                   3 readback mismatch
// ---------------------------------------------------------------------------
module controller_instruction_rom_loader #(
  parameter int ADDR_WIDTH = 13,
  parameter int DEPTH      = 8192
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_chipsel,
  output logic                  mem_write,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_byteen,
  output logic                  mem_clken,
  input  logic [31:0]           mem_rdata,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            err_code
);

  // One extra bit so the index can reach DEPTH without wrapping.
  localparam int          IDX_W   = ADDR_WIDTH + 1;
  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HDR0   = 3'd1,
    S_HDR1   = 3'd2,
    S_DATA   = 3'd3,
    S_CSUM   = 3'd4,
    S_VERIFY = 3'd5,
    S_DONE   = 3'd6,
    S_ERROR  = 3'd7
  } state_e;

  state_e                  state_q;
  logic [15:0]             len_q;
  logic [IDX_W-1:0]        idx_q;
  logic [1:0]              byte_cnt_q;
  logic [23:0]             pack_q;
  logic [31:0]             sum_w_q;
  logic [31:0]             sum_r_q;
  logic                    rd_issue_q;
  logic                    rd_last_q;
  logic                    cap_q;
  logic                    cap_last_q;
  logic [ADDR_WIDTH-1:0]   mem_address_q;
  logic                    mem_chipsel_q;
  logic                    mem_write_q;
  logic [31:0]             mem_wdata_q;
  logic                    done_q;
  logic                    error_q;
  logic [1:0]              err_code_q;

  logic                    in_state;
  logic                    accept;
  logic [31:0]             word_d;
  logic [15:0]             hdr_len_d;
  logic [31:0]             sum_r_d;
  logic                    idx_last;
  logic                    issue_more;

  assign in_state   = (state_q == S_HDR0) || (state_q == S_HDR1) ||
                      (state_q == S_DATA) || (state_q == S_CSUM);
  assign accept     = in_valid && in_state;
  // pack_q holds the three earlier bytes of the word, oldest in the low byte.
  assign word_d     = {in_data, pack_q};
  assign hdr_len_d  = {in_data, len_q[7:0]};
  assign sum_r_d    = sum_r_q + mem_rdata;
  assign idx_last   = (16'(idx_q) == (len_q - 16'd1));
  assign issue_more = (16'(idx_q) < len_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      len_q         <= '0;
      idx_q         <= '0;
      byte_cnt_q    <= '0;
      pack_q        <= '0;
      sum_w_q       <= '0;
      sum_r_q       <= '0;
      rd_issue_q    <= 1'b0;
      rd_last_q     <= 1'b0;
      cap_q         <= 1'b0;
      cap_last_q    <= 1'b0;
      mem_address_q <= '0;
      mem_chipsel_q <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_wdata_q   <= '0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      err_code_q    <= 2'd0;
    end else begin
      // Bus strobes are single-cycle unless re-asserted below.
      mem_chipsel_q <= 1'b0;
      mem_write_q   <= 1'b0;
      rd_issue_q    <= 1'b0;
      rd_last_q     <= 1'b0;
      // Read data arrives one cycle after the address is on the bus.
      cap_q         <= rd_issue_q;
      cap_last_q    <= rd_last_q;

      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state_q    <= S_HDR0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= 2'd0;
            idx_q      <= '0;
            byte_cnt_q <= '0;
            sum_w_q    <= '0;
            sum_r_q    <= '0;
          end
        end

        S_HDR0: begin
          if (accept) begin
            len_q   <= {8'h00, in_data};
            state_q <= S_HDR1;
          end
        end

        S_HDR1: begin
          if (accept) begin
            len_q <= hdr_len_d;
            if ((hdr_len_d == 16'd0) || ({1'b0, hdr_len_d} > DEPTH_W)) begin
              state_q    <= S_ERROR;
              error_q    <= 1'b1;
              err_code_q <= 2'd1;
            end else begin
              state_q <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (accept) begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              // Write register is separate from pack_q, so the next byte can
              // be accepted while this word is on the bus.
              mem_chipsel_q <= 1'b1;
              mem_write_q   <= 1'b1;
              mem_address_q <= idx_q[ADDR_WIDTH-1:0];
              mem_wdata_q   <= word_d;
              sum_w_q       <= sum_w_q + word_d;
              idx_q         <= idx_q + 1'b1;
              if (idx_last) begin
                state_q <= S_CSUM;
              end
            end else begin
              pack_q <= word_d[31:8];
            end
          end
        end

        S_CSUM: begin
          if (accept) begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              if (word_d != sum_w_q) begin
                state_q    <= S_ERROR;
                error_q    <= 1'b1;
                err_code_q <= 2'd2;
              end else begin
                state_q <= S_VERIFY;
                idx_q   <= '0;
              end
            end else begin
              pack_q <= word_d[31:8];
            end
          end
        end

        S_VERIFY: begin
          if (issue_more) begin
            mem_chipsel_q <= 1'b1;
            mem_address_q <= idx_q[ADDR_WIDTH-1:0];
            rd_issue_q    <= 1'b1;
            rd_last_q     <= idx_last;
            idx_q         <= idx_q + 1'b1;
          end
          if (cap_q) begin
            sum_r_q <= sum_r_d;
            if (cap_last_q) begin
              if (sum_r_d == sum_w_q) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end else begin
                state_q    <= S_ERROR;
                error_q    <= 1'b1;
                err_code_q <= 2'd3;
              end
            end
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = in_state;
  assign busy        = (state_q != S_IDLE) && (state_q != S_DONE) &&
                       (state_q != S_ERROR);
  // The CPU is held for exactly the span the loader is busy.
  assign cpu_hold    = busy;
  assign mem_address = mem_address_q;
  assign mem_chipsel = mem_chipsel_q;
  assign mem_write   = mem_write_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_byteen  = 4'hF;
  assign mem_clken   = 1'b1;
  assign done        = done_q;
  assign error       = error_q;
  assign err_code    = err_code_q;

endmodule

// File: tb/tb_controller_instruction_rom_loader.sv
// ---------------------------------------------------------------------------
// tb_controller_instruction_rom_loader
//
// Directed bench for the instruction RAM boot loader. A synchronous RAM model
// answers the s2 port (optional readback corruption of word 0). Expected
// writes are queued as {address, data} when their bytes are sent and checked
// as they appear on the bus. Inputs are driven and outputs sampled on the
// falling clock edge.
// ---------------------------------------------------------------------------
module tb_controller_instruction_rom_loader;

  localparam int AW = 13;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] mem_address;
  logic          mem_chipsel;
  logic          mem_write;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_byteen;
  logic          mem_clken;
  logic [31:0]   mem_rdata = 32'h0;
  logic          cpu_hold;
  logic          busy;
  logic          done;
  logic          error;
  logic [1:0]    err_code;

  always #5 clk = ~clk;

  controller_instruction_rom_loader #(.ADDR_WIDTH(AW), .DEPTH(8192)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .mem_address (mem_address),
    .mem_chipsel (mem_chipsel),
    .mem_write   (mem_write),
    .mem_wdata   (mem_wdata),
    .mem_byteen  (mem_byteen),
    .mem_clken   (mem_clken),
    .mem_rdata   (mem_rdata),
    .cpu_hold    (cpu_hold),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .err_code    (err_code)
  );

  // ---------------- scoreboard state ----------------
  int            vec_cnt = 0;
  int            err_cnt = 0;
  int            wr_cnt  = 0;
  int            rd_cnt  = 0;
  int            rd_next = 0;
  int            viol_cnt = 0;
  logic [AW-1:0] last_wr_addr = '0;
  logic [31:0]   last_wr_data = '0;
  logic          corrupt = 1'b0;
  logic [44:0]   exp_q[$];   // {address, data}
  logic [31:0]   frame_q[$];
  logic [31:0]   ram [0:8191];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Synchronous RAM model: read data valid the cycle after the address.
  always @(posedge clk) begin
    if (mem_chipsel && mem_write) ram[mem_address] <= mem_wdata;
    if (mem_chipsel && !mem_write)
      mem_rdata <= ram[mem_address] ^
                   ((corrupt && (mem_address == '0)) ? 32'h1 : 32'h0);
  end

  // Bus monitor.
  always @(negedge clk) begin
    logic [44:0] e;
    if (mem_chipsel && mem_write) begin
      wr_cnt++;
      last_wr_addr = mem_address;
      last_wr_data = mem_wdata;
      if (!in_ready) viol_cnt++;
      vec_cnt++;
      assert (exp_q.size() > 0) else begin
        err_cnt++;
        $error("FAIL wr_expected: unexpected write @%h data %h", mem_address, mem_wdata);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("wr_addr", {19'b0, mem_address}, {19'b0, e[44:32]});
        check("wr_data", mem_wdata, e[31:0]);
      end
    end
    if (mem_chipsel && !mem_write) begin
      check("rd_addr", {19'b0, mem_address}, 32'(rd_next));
      rd_next++;
      rd_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd0);
    check({tag, "_addr"},     {19'b0, mem_address}, 32'd0);
    check({tag, "_chipsel"},  {31'b0, mem_chipsel}, 32'd0);
    check({tag, "_write"},    {31'b0, mem_write}, 32'd0);
    check({tag, "_wdata"},    mem_wdata, 32'd0);
    check({tag, "_byteen"},   {28'b0, mem_byteen}, 32'hF);
    check({tag, "_clken"},    {31'b0, mem_clken}, 32'd1);
    check({tag, "_cpu_hold"}, {31'b0, cpu_hold}, 32'd0);
    check({tag, "_busy"},     {31'b0, busy}, 32'd0);
    check({tag, "_done"},     {31'b0, done}, 32'd0);
    check({tag, "_error"},    {31'b0, error}, 32'd0);
    check({tag, "_err_code"}, {30'b0, err_code}, 32'd0);
  endtask

  task automatic clear_counts();
    wr_cnt  = 0;
    rd_cnt  = 0;
    rd_next = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called and returns just after a falling edge.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int waited;
    if (gaps && ($urandom_range(0, 3) == 0)) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    waited   = 0;
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 200) check("byte_accept", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    send_byte(w[7:0], gaps);
    send_byte(w[15:8], gaps);
    send_byte(w[23:16], gaps);
    send_byte(w[31:24], gaps);
  endtask

  // Header, then (when the length is legal) frame_q words and the checksum.
  task automatic send_frame(input logic [15:0] n, input logic [31:0] csum,
                            input bit gaps, input bit body);
    send_byte(n[7:0], gaps);
    send_byte(n[15:8], gaps);
    if (body) begin
      for (int i = 0; i < frame_q.size(); i++) begin
        exp_q.push_back({AW'(i), frame_q[i]});
        send_word(frame_q[i], gaps);
      end
      send_word(csum, gaps);
    end
  endtask

  task automatic wait_end(input int budget);
    int waited = 0;
    while (!(done || error) && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= budget) check("end_timeout", {31'b0, done | error}, 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    reset = 1'b0;
    @(negedge clk);

    // 1: two-word image, good checksum
    clear_counts();
    pulse_start();
    check("t1_busy", {31'b0, busy}, 32'd1);
    check("t1_cpu_hold", {31'b0, cpu_hold}, 32'd1);
    check("t1_in_ready", {31'b0, in_ready}, 32'd1);
    frame_q.delete();
    frame_q.push_back(32'h11223344);
    frame_q.push_back(32'hA5A5A5A5);
    send_frame(16'd2, 32'hB6C7D8E9, 1'b0, 1'b1);
    wait_end(100);
    check("t1_done", {31'b0, done}, 32'd1);
    check("t1_error", {31'b0, error}, 32'd0);
    check("t1_err_code", {30'b0, err_code}, 32'd0);
    check("t1_cpu_hold_low", {31'b0, cpu_hold}, 32'd0);
    check("t1_busy_low", {31'b0, busy}, 32'd0);
    check("t1_wr_cnt", 32'(wr_cnt), 32'd2);
    check("t1_rd_cnt", 32'(rd_cnt), 32'd2);
    check("t1_exp_left", 32'(exp_q.size()), 32'd0);
    // Bytes offered in DONE are not taken.
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (3) @(negedge clk);
    check("t1_idle_ready", {31'b0, in_ready}, 32'd0);
    check("t1_done_hold", {31'b0, done}, 32'd1);
    in_valid = 1'b0;

    // 2a: N = 0
    clear_counts();
    pulse_start();
    check("t2a_done_clr", {31'b0, done}, 32'd0);
    send_frame(16'd0, 32'h0, 1'b0, 1'b0);
    wait_end(20);
    check("t2a_error", {31'b0, error}, 32'd1);
    check("t2a_err_code", {30'b0, err_code}, 32'd1);
    check("t2a_wr_cnt", 32'(wr_cnt), 32'd0);
    check("t2a_cpu_hold", {31'b0, cpu_hold}, 32'd0);

    // 2b: N = DEPTH + 1
    clear_counts();
    pulse_start();
    check("t2b_error_clr", {31'b0, error}, 32'd0);
    check("t2b_code_clr", {30'b0, err_code}, 32'd0);
    send_frame(16'd8193, 32'h0, 1'b0, 1'b0);
    wait_end(20);
    check("t2b_error", {31'b0, error}, 32'd1);
    check("t2b_err_code", {30'b0, err_code}, 32'd1);
    check("t2b_wr_cnt", 32'(wr_cnt), 32'd0);

    // 3: bad checksum
    clear_counts();
    pulse_start();
    frame_q.delete();
    frame_q.push_back(32'h00000001);
    send_frame(16'd1, 32'h00000002, 1'b1, 1'b1);
    wait_end(50);
    check("t3_error", {31'b0, error}, 32'd1);
    check("t3_err_code", {30'b0, err_code}, 32'd2);
    check("t3_wr_cnt", 32'(wr_cnt), 32'd1);
    check("t3_rd_cnt", 32'(rd_cnt), 32'd0);

    // 4: readback of word 0 corrupted
    clear_counts();
    corrupt = 1'b1;
    pulse_start();
    frame_q.delete();
    frame_q.push_back(32'hDEADBEEF);
    frame_q.push_back(32'h00000010);
    send_frame(16'd2, 32'hDEADBEFF, 1'b0, 1'b1);
    wait_end(50);
    check("t4_error", {31'b0, error}, 32'd1);
    check("t4_err_code", {30'b0, err_code}, 32'd3);
    check("t4_done", {31'b0, done}, 32'd0);
    check("t4_wr_cnt", 32'(wr_cnt), 32'd2);
    check("t4_rd_cnt", 32'(rd_cnt), 32'd2);
    corrupt = 1'b0;

    // 5: full depth, words = index, random stalls
    clear_counts();
    pulse_start();
    frame_q.delete();
    for (int i = 0; i < 8192; i++) frame_q.push_back(32'(i));
    send_frame(16'd8192, 32'h01FFF000, 1'b1, 1'b1);
    wait_end(20000);
    check("t5_done", {31'b0, done}, 32'd1);
    check("t5_err_code", {30'b0, err_code}, 32'd0);
    check("t5_wr_cnt", 32'(wr_cnt), 32'd8192);
    check("t5_rd_cnt", 32'(rd_cnt), 32'd8192);
    check("t5_last_addr", {19'b0, last_wr_addr}, 32'h1FFF);
    check("t5_last_data", last_wr_data, 32'h00001FFF);

    // 6: reset after 5 data bytes, then a clean reload
    clear_counts();
    pulse_start();
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    exp_q.push_back({AW'(0), 32'h11223344});
    send_word(32'h11223344, 1'b0);
    send_byte(8'h99, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("mid_rst");
    check("t6_wr_cnt", 32'(wr_cnt), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    clear_counts();
    pulse_start();
    frame_q.delete();
    frame_q.push_back(32'h01020304);
    frame_q.push_back(32'hFFFFFFFF);
    frame_q.push_back(32'h00000005);
    send_frame(16'd3, 32'h01020308, 1'b1, 1'b1);
    wait_end(100);
    check("t6_done", {31'b0, done}, 32'd1);
    check("t6_err_code", {30'b0, err_code}, 32'd0);
    check("t6_wr_cnt", 32'(wr_cnt), 32'd3);
    check("t6_rd_cnt", 32'(rd_cnt), 32'd3);

    check("write_in_verify", 32'(viol_cnt), 32'd0);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
